mulfsm_arbiter: RTL and testbench

- Round-robin arbiter sharing one multi-cycle req/ack multiplier (mul32x32_fsm, as wrapped by hls_MulFSM) between NREQ HLS requesters.
- Latches the winner's operands, drives the single multiplier handshake, and returns the product with a one-cycle ack to the winner only.
- A watchdog aborts a hung operation.
- Sits between the generated HLS cores and the one shared multiplier instance in the SoC top.

---
 rtl/mularb_pkg.sv | 17 +
 rtl/mulfsm_arbiter_rr_pick.sv | 31 +++
 rtl/mulfsm_arbiter.sv | 142 ++++++++++++++
 tb/tb_mulfsm_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mularb_pkg.sv
// Shared types and helpers for the multiplier arbiter slice.
package mularb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    // Width of an index into an n-entry vector (never below one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mulfsm_arbiter_rr_pick.sv
// Rotating priority encoder: first set request strictly after the last winner.
module rr_pick
    import mularb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]              i_req,
    input  logic [idx_width(NREQ)-1:0]   i_last,
    output logic [idx_width(NREQ)-1:0]   o_winner,
    output logic                         o_any
);

    localparam int unsigned IW = idx_width(NREQ);

    logic [IW-1:0] w_idx;

    // Scan (last+1 .. last+NREQ) mod NREQ and keep the first hit.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IW'((32'(i_last) + k) % NREQ);
            if (!o_any && i_req[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mulfsm_arbiter.sv
// Round-robin arbiter sharing one req/ack multiplier between NREQ requesters,
// with a watchdog that aborts an operation the multiplier never acknowledges.
module mulfsm_arbiter
    import mularb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WIDTH-1:0]       p0,
    input  logic [NREQ*WIDTH-1:0]       p1,
    output logic [NREQ-1:0]             ack,
    output logic [NREQ-1:0]             err,
    output logic [WIDTH-1:0]            out,
    output logic                        busy,
    output logic [idx_width(NREQ)-1:0]  gnt_idx,
    output logic                        mul_req,
    output logic [WIDTH-1:0]            mul_p0,
    output logic [WIDTH-1:0]            mul_p1,
    input  logic                        mul_ack,
    input  logic [WIDTH-1:0]            mul_out
);

    localparam int unsigned IW  = idx_width(NREQ);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    state_t            r_state, w_state_nxt;
    logic [IW-1:0]     r_last,  w_last_nxt;
    logic [WDW-1:0]    r_wdog,  w_wdog_nxt;
    logic [NREQ-1:0]   r_ack,   w_ack_nxt;
    logic [NREQ-1:0]   r_err,   w_err_nxt;
    logic [WIDTH-1:0]  r_out,   w_out_nxt;
    logic              r_busy,  w_busy_nxt;
    logic [IW-1:0]     r_gnt,   w_gnt_nxt;
    logic              r_mreq,  w_mreq_nxt;
    logic [WIDTH-1:0]  r_p0,    w_p0_nxt;
    logic [WIDTH-1:0]  r_p1,    w_p1_nxt;

    logic [IW-1:0]     w_win;
    logic              w_any;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    assign ack     = r_ack;
    assign err     = r_err;
    assign out     = r_out;
    assign busy    = r_busy;
    assign gnt_idx = r_gnt;
    assign mul_req = r_mreq;
    assign mul_p0  = r_p0;
    assign mul_p1  = r_p1;

    // Next-state and next-output logic; ack/err are set on the completing
    // edge so their single-cycle pulse coincides with the DONE state.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_wdog_nxt  = r_wdog;
        w_ack_nxt   = '0;
        w_err_nxt   = '0;
        w_out_nxt   = r_out;
        w_busy_nxt  = r_busy;
        w_gnt_nxt   = r_gnt;
        w_mreq_nxt  = r_mreq;
        w_p0_nxt    = r_p0;
        w_p1_nxt    = r_p1;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_p0_nxt    = p0[w_win*WIDTH +: WIDTH];
                    w_p1_nxt    = p1[w_win*WIDTH +: WIDTH];
                    w_gnt_nxt   = w_win;
                    w_last_nxt  = w_win;
                    w_mreq_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_wdog_nxt  = '0;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_wdog_nxt = r_wdog + 1'b1;
                if (mul_ack) begin
                    w_out_nxt        = mul_out;
                    w_mreq_nxt       = 1'b0;
                    w_ack_nxt[r_gnt] = 1'b1;
                    w_state_nxt      = DONE;
                end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                    w_mreq_nxt       = 1'b0;
                    w_err_nxt[r_gnt] = 1'b1;
                    w_state_nxt      = DONE;
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_last  <= IW'(NREQ - 1);
            r_wdog  <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_gnt   <= '0;
            r_mreq  <= 1'b0;
            r_p0    <= '0;
            r_p1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_wdog  <= w_wdog_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_gnt   <= w_gnt_nxt;
            r_mreq  <= w_mreq_nxt;
            r_p0    <= w_p0_nxt;
            r_p1    <= w_p1_nxt;
        end
    end

endmodule

// File: tb/tb_mulfsm_arbiter.sv
// Scoreboard bench for mulfsm_arbiter with a behavioural multiplier model.
module tb_mulfsm_arbiter;

    typedef struct packed {
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [31:0] out;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] p0  = '0;
    logic [127:0] p1  = '0;
    logic [3:0]   ack, err;
    logic [31:0]  out;
    logic         busy;
    logic [1:0]   gnt_idx;
    logic         mul_req;
    logic [31:0]  mul_p0, mul_p1;
    logic         mul_ack;
    logic [31:0]  mul_out;

    // multiplier model controls
    int           lat  = 5;
    bit           mute = 1'b0;
    int           mcnt = 0;
    logic         m_ack = 1'b0;
    logic [31:0]  m_out = '0;
    logic         man_ack = 1'b0;
    logic [31:0]  man_out = '0;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    assign mul_ack = m_ack | man_ack;
    assign mul_out = man_ack ? man_out : m_out;

    mulfsm_arbiter #(
        .NREQ    (4),
        .WIDTH   (32),
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .p0      (p0),
        .p1      (p1),
        .ack     (ack),
        .err     (err),
        .out     (out),
        .busy    (busy),
        .gnt_idx (gnt_idx),
        .mul_req (mul_req),
        .mul_p0  (mul_p0),
        .mul_p1  (mul_p1),
        .mul_ack (mul_ack),
        .mul_out (mul_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // Multiplier: pulse ack after 'lat' cycles of mul_req with the product.
    always @(negedge clk) begin
        m_ack = 1'b0;
        if (!rst || !mul_req || mute) begin
            mcnt = 0;
        end else begin
            mcnt++;
            if (mcnt == lat) begin
                m_ack = 1'b1;
                m_out = mul_p0 * mul_p1;
                mcnt  = 0;
            end
        end
    end

    // Monitor: every ack/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (ack != '0 || err != '0)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_completion: ack=%b err=%b out=%0d, none expected", ack, err, out);
            end else begin
                e = sb.pop_front();
                if (ack !== e.ack || err !== e.err || out !== e.out) begin
                    fails++;
                    $display("FAIL completion: got ack=%b err=%b out=%0d, expected ack=%b err=%b out=%0d",
                             ack, err, out, e.ack, e.err, e.out);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        p0[i*32 +: 32] = a;
        p1[i*32 +: 32] = b;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] e, input logic [31:0] o);
        exp_t x;
        x.ack = a;
        x.err = e;
        x.out = o;
        sb.push_back(x);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ack | err) == '0 && n < 200);
        if ((ack | err) == '0) begin
            tests++;
            fails++;
            $display("FAIL wait_done: no ack/err within 200 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int hi;
        repeat (3) @(negedge clk);
        check("rst_ack_err", {ack, err}, 0);
        check("rst_out", out, 0);
        check("rst_busy_mreq_gnt", {busy, mul_req, gnt_idx}, 0);
        check("rst_mul_ops", {mul_p0, mul_p1}, 0);
        rst = 1'b1;

        // single request, multiplier latency 5
        lat = 5;
        set_ops(0, 7, 6);
        push(4'b0001, 4'b0000, 42);
        req = 4'b0001;
        @(negedge clk);
        check("single_mul_req", mul_req, 1);
        check("single_mul_p0", mul_p0, 7);
        check("single_mul_p1", mul_p1, 6);
        check("single_busy_gnt", {busy, gnt_idx}, {1'b1, 2'd0});
        wait_done();
        req = '0;
        @(negedge clk);
        check("single_busy_after", busy, 0);
        check("single_ack_after", ack, 0);

        // all four requesting after reset: strict rotation 0,1,2,3,0
        do_reset();
        lat = 3;
        for (int i = 0; i < 4; i++) set_ops(i, i + 2, 10);
        push(4'b0001, 4'b0000, 20);
        push(4'b0010, 4'b0000, 30);
        push(4'b0100, 4'b0000, 40);
        push(4'b1000, 4'b0000, 50);
        push(4'b0001, 4'b0000, 20);
        req = 4'b1111;
        repeat (5) wait_done();
        req = '0;
        @(negedge clk);

        // rotation skip: last grant 1, req 0101 -> 2 then 0
        do_reset();
        set_ops(1, 11, 11);
        push(4'b0010, 4'b0000, 121);
        req = 4'b0010;
        wait_done();
        req = '0;
        @(negedge clk);
        set_ops(0, 3, 5);
        set_ops(2, 9, 4);
        push(4'b0100, 4'b0000, 36);
        push(4'b0001, 4'b0000, 15);
        req = 4'b0101;
        wait_done();
        check("skip_gnt_first", gnt_idx, 2);
        wait_done();
        check("skip_gnt_second", gnt_idx, 0);
        req = '0;
        @(negedge clk);

        // timeout on requester 2: err pulse, out keeps 15
        mute = 1'b1;
        push(4'b0000, 4'b0100, 15);
        req = 4'b0100;
        hi = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if ((ack | err) != '0) break;
            if (mul_req) hi++;
        end
        check("timeout_err", err, 4'b0100);
        check("timeout_mul_req_cycles", hi, 16);
        check("timeout_mul_req_low", mul_req, 0);
        req = '0;
        mute = 1'b0;
        @(negedge clk);
        set_ops(3, 100, 200);
        push(4'b1000, 4'b0000, 20000);
        req = 4'b1000;
        wait_done();
        req = '0;
        @(negedge clk);

        // ack coincident with the timeout cycle wins
        lat = 16;
        set_ops(0, 6, 7);
        push(4'b0001, 4'b0000, 42);
        req = 4'b0001;
        wait_done();
        check("coincident_err", err, 0);
        req = '0;
        lat = 3;
        @(negedge clk);

        // stray ack while idle is ignored
        man_out = 999;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        check("stray_out", out, 42);
        check("stray_ack_err", {ack, err}, 0);
        check("stray_busy", busy, 0);

        // reset during WAIT drops the op
        lat = 10;
        req = 4'b0100;
        repeat (3) @(negedge clk);
        check("midop_mul_req", mul_req, 1);
        rst = 1'b0;
        @(negedge clk);
        check("midop_rst_mreq_busy", {mul_req, busy}, 0);
        check("midop_rst_ack_gnt", {ack, gnt_idx}, 0);
        check("midop_rst_out", out, 0);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        lat = 3;
        set_ops(0, 5, 5);
        set_ops(3, 7, 8);
        push(4'b0001, 4'b0000, 25);
        push(4'b1000, 4'b0000, 56);
        req = 4'b1001;
        wait_done();
        req = 4'b1000;
        wait_done();
        req = '0;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
